// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared constants for the seven-segment display path: segment patterns
// ({g,f,e,d,c,b,a}, active-high), scan-decoder FSM states and defaults.
package seven_segment_scan_decoder_pkg;

    localparam int unsigned DEFAULT_NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {
        S_WAIT,
        S_HELD
    } state_t;

endpackage

// File: rtl/seven_segment_scan_decoder_if.sv
// Multiplexed display bus as observed by the scan decoder, plus its readback outputs.
interface seven_segment_scan_decoder_if
    import seven_segment_scan_decoder_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   pattern_err;
    logic                    update;
    logic                    err_pulse;

    modport master (
        output seg_in, an_in,
        input  digits_out, digit_valid, pattern_err, update, err_pulse
    );

    modport slave (
        input  seg_in, an_in,
        output digits_out, digit_valid, pattern_err, update, err_pulse
    );
endinterface

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational segment-pattern to hex lookup; shares the encoder's pattern table.
module seven_segment_pattern_decoder
    import seven_segment_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       hit
);
    always_comb begin
        hex = '0;
        hit = 1'b1;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Debounces each dwell of a scanned 7-segment bus and decodes stable patterns
// back into a per-digit hex register file.
module seven_segment_scan_decoder
    import seven_segment_scan_decoder_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = DEFAULT_NUM_DIGITS,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
)(
    input  logic                         clk,
    input  logic                         rst_n,
    seven_segment_scan_decoder_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   smp_an;
    logic [6:0]              smp_seg;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    same, commit;
    logic                    an_onehot, an_multi;
    logic [3:0]              hex;
    logic                    hit;

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q, perr_q;
    logic                    update_q, err_q;

    seven_segment_pattern_decoder u_dec (
        .seg (smp_seg),
        .hex (hex),
        .hit (hit)
    );

    always_comb begin
        an_multi  = (smp_an & (smp_an - 1'b1)) != '0;
        an_onehot = (smp_an != '0) && !an_multi;
    end

    // A change on the edge of a would-be commit takes priority and restarts the dwell.
    always_comb begin
        same    = {bus.an_in, bus.seg_in} == {smp_an, smp_seg};
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!same) begin
            state_d = S_WAIT;
            cnt_d   = '0;
        end else if (state_q == S_WAIT) begin
            if (cnt_q == LAST_CNT) begin
                commit  = 1'b1;
                state_d = S_HELD;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            smp_an  <= '0;
            smp_seg <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smp_an  <= bus.an_in;
            smp_seg <= bus.seg_in;
        end
    end

    // Blanking (an all-zero) commits silently; multi-hot only raises err_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            perr_q   <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            update_q <= commit && an_onehot && hit;
            err_q    <= commit && (an_multi || (an_onehot && !hit));
            if (commit && an_onehot) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (smp_an[i]) begin
                        if (hit) begin
                            digits_q[4*i +: 4] <= hex;
                            valid_q[i]         <= 1'b1;
                            perr_q[i]          <= 1'b0;
                        end else begin
                            valid_q[i]         <= 1'b0;
                            perr_q[i]          <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.pattern_err = perr_q;
    assign bus.update      = update_q;
    assign bus.err_pulse   = err_q;
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Scoreboard bench: a dwell-level model predicts commits and pulse times; a monitor checks pulses.
module tb_seven_segment_scan_decoder;
    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;

    typedef struct {
        bit          is_err;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .CNT_W         (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    logic [3:0]    m_dig [ND];
    bit            m_val [ND];
    bit            m_err [ND];
    logic [ND-1:0] last_an;
    logic [6:0]    last_seg;
    int unsigned   start;
    bit            committed;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_state();
        logic [4*ND-1:0] d;
        logic [ND-1:0]   v, e;
        for (int i = 0; i < int'(ND); i++) begin
            d[4*i +: 4] = m_dig[i];
            v[i] = m_val[i];
            e[i] = m_err[i];
        end
        check("digits_out", 32'(bus.digits_out), 32'(d));
        check("digit_valid", 32'(bus.digit_valid), 32'(v));
        check("pattern_err", 32'(bus.pattern_err), 32'(e));
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(ND); i++) begin
            m_dig[i] = '0;
            m_val[i] = 1'b0;
            m_err[i] = 1'b0;
        end
        last_an   = '0;
        last_seg  = '0;
        start     = cyc;
        committed = 1'b0;
    endtask

    task automatic apply_commit(input int unsigned c);
        int k;
        int idx;
        int h;
        exp_t x;
        k = $countones(last_an);
        x.cyc = c;
        if (k == 1) begin
            idx = 0;
            for (int i = 0; i < int'(ND); i++)
                if (last_an[i]) idx = i;
            h = lookup(last_seg);
            if (h >= 0) begin
                m_dig[idx] = 4'(h);
                m_val[idx] = 1'b1;
                m_err[idx] = 1'b0;
                x.is_err = 1'b0;
            end else begin
                m_val[idx] = 1'b0;
                m_err[idx] = 1'b1;
                x.is_err = 1'b1;
            end
            exp_q.push_back(x);
        end else if (k > 1) begin
            x.is_err = 1'b1;
            exp_q.push_back(x);
        end
    endtask

    // Called at a negedge; holds the value for n rising edges.
    task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int unsigned n);
        bus.an_in  = an;
        bus.seg_in = seg;
        if ({an, seg} != {last_an, last_seg}) begin
            last_an   = an;
            last_seg  = seg;
            start     = cyc + 1;
            committed = 1'b0;
        end
        if (!committed && (start + SC <= cyc + n)) begin
            committed = 1'b1;
            apply_commit(start + SC);
        end
        repeat (n) @(negedge clk);
        check_state();
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (bus.update === 1'b1 || bus.err_pulse === 1'b1) begin
                tests++;
                if (bus.update === 1'b1 && bus.err_pulse === 1'b1) begin
                    fails++;
                    $display("FAIL pulse_exclusive: update=1 err_pulse=1, expected at most one (cycle %0d)", cyc);
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: update=%0b err_pulse=%0b, expected none (cycle %0d)",
                             bus.update, bus.err_pulse, cyc);
                end else begin
                    x = exp_q.pop_front();
                    if (x.is_err != bus.err_pulse || x.cyc != cyc) begin
                        fails++;
                        $display("FAIL pulse: got err_pulse=%0b at cycle %0d, expected err_pulse=%0b at cycle %0d",
                                 bus.err_pulse, cyc, x.is_err, x.cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic [ND-1:0] an;
        logic [6:0]    seg;
        int unsigned   mode;

        bus.an_in  = '0;
        bus.seg_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        check("update_rst", 32'(bus.update), 32'd0);
        check("err_pulse_rst", 32'(bus.err_pulse), 32'd0);
        rst_n = 1'b1;
        model_reset();

        hold(4'b0001, 7'h5B, 6);
        hold(4'b0001, 7'h3F, 8);
        hold(4'b0010, 7'h06, 8);
        hold(4'b0100, 7'h7C, 8);
        hold(4'b1000, 7'h71, 8);
        check("scan_digits", 32'(bus.digits_out), 32'h0000_FB10);
        hold(4'b0100, 7'h7E, 6);
        for (int i = 0; i < 2; i++) begin
            hold(4'b0001, 7'h06, 3);
            hold(4'b0001, 7'h3F, 3);
        end
        hold(4'b0001, 7'h06, 3);
        hold(4'b0001, 7'h3F, 5);
        hold(4'b0011, 7'h06, 6);
        hold(4'b0000, 7'h00, 10);

        hold(4'b0010, 7'h4F, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        check("update_midrst", 32'(bus.update), 32'd0);
        check("err_pulse_midrst", 32'(bus.err_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        hold(4'b0010, 7'h4F, 6);

        for (int r = 0; r < 60; r++) begin
            mode = $urandom_range(0, 9);
            an   = last_an;
            seg  = last_seg;
            if (mode <= 5) begin
                an  = ND'(1) << $urandom_range(0, ND - 1);
                seg = ($urandom_range(0, 9) < 7) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
            end else if (mode == 6) begin
                an  = '0;
                seg = 7'($urandom_range(0, 127));
            end else if (mode == 7) begin
                do an = ND'($urandom_range(0, (1 << ND) - 1)); while ($countones(an) < 2);
                seg = seg_tab[$urandom_range(0, 15)];
            end
            hold(an, seg, $urandom_range(1, 8));
        end

        hold(4'b0000, 7'h00, 10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
